// File: rtl/conv_layer_if.sv
// ============================================================================
// Module      : conv_layer_if
// Description : Pixel stream bundle for conv_layer (enable, pixel in, sum out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_layer_if #(
    parameter int D_WIDTH    = 8,
    parameter int Q_WIDTH    = 16,
    parameter int D_CHANNELS = 2,
    parameter int Q_CHANNELS = 2
);
    logic                          clk_en;
    logic [D_CHANNELS*D_WIDTH-1:0] input_data;
    logic [Q_CHANNELS*Q_WIDTH-1:0] output_data;
    logic                          valid;

    modport master (
        output clk_en,
        output input_data,
        input  output_data,
        input  valid
    );

    modport slave (
        input  clk_en,
        input  input_data,
        output output_data,
        output valid
    );
endinterface

`default_nettype wire

// File: rtl/conv_layer.sv
// ============================================================================
// Module      : conv_layer
// Description : Streaming unit-weight 2-D window sum over all input channels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_layer #(
    parameter int D_WIDTH     = 8,
    parameter int Q_WIDTH     = 16,
    parameter int D_CHANNELS  = 2,
    parameter int Q_CHANNELS  = 2,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 64
) (
    input  wire logic     clk,
    input  wire logic     rst,
    conv_layer_if.slave   bus
);

    localparam int DEPTH = (FILTER_SIZE - 1) * IMAGE_SIZE + (FILTER_SIZE - 1);
    localparam int PIX_W = D_CHANNELS * D_WIDTH;
    localparam int TAPS  = FILTER_SIZE * FILTER_SIZE;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry k holds the pixel accepted k enables ago
    logic [PIX_W-1:0] line_buf_q [1:DEPTH];
    logic [PIX_W-1:0] line_buf_d [1:DEPTH];
    logic [CNT_W-1:0] fill_count_q;
    logic [CNT_W-1:0] fill_count_d;

    logic [PIX_W-1:0]   w_tap_pix [TAPS];
    logic [Q_WIDTH-1:0] w_window_sum;

    always_comb begin
        line_buf_d   = line_buf_q;
        fill_count_d = fill_count_q;
        if (bus.clk_en) begin
            line_buf_d[1] = bus.input_data;
            for (int i = 2; i <= DEPTH; i++) begin
                line_buf_d[i] = line_buf_q[i-1];
            end
            if (fill_count_q < CNT_W'(DEPTH)) begin
                fill_count_d = fill_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                line_buf_q[i] <= '0;
            end
            fill_count_q <= '0;
        end else begin
            line_buf_q   <= line_buf_d;
            fill_count_q <= fill_count_d;
        end
    end

    // Offset 0 is the pixel currently presented, which is not yet stored
    generate
        for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
            for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
                localparam int OFF = r * IMAGE_SIZE + c;
                if (OFF == 0) begin : g_live
                    assign w_tap_pix[0] = bus.input_data;
                end else begin : g_stored
                    assign w_tap_pix[r*FILTER_SIZE+c] = line_buf_q[OFF];
                end
            end
        end
    endgenerate

    always_comb begin
        w_window_sum = '0;
        for (int t = 0; t < TAPS; t++) begin
            for (int k = 0; k < D_CHANNELS; k++) begin
                w_window_sum = w_window_sum
                             + Q_WIDTH'(w_tap_pix[t][(D_CHANNELS-1-k)*D_WIDTH +: D_WIDTH]);
            end
        end
    end

    generate
        for (genvar q = 0; q < Q_CHANNELS; q++) begin : g_out
            assign bus.output_data[(Q_CHANNELS-1-q)*Q_WIDTH +: Q_WIDTH] = w_window_sum;
        end
    endgenerate

    assign bus.valid = (fill_count_q == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_conv_layer.sv
// ============================================================================
// Module      : tb_conv_layer
// Description : Scoreboard bench for conv_layer (default, Q_WIDTH=10, 3x3/8)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_layer_if #(.D_WIDTH(8), .Q_WIDTH(16), .D_CHANNELS(2), .Q_CHANNELS(2)) if0 ();
    conv_layer_if #(.D_WIDTH(8), .Q_WIDTH(10), .D_CHANNELS(2), .Q_CHANNELS(2)) if1 ();
    conv_layer_if #(.D_WIDTH(8), .Q_WIDTH(16), .D_CHANNELS(2), .Q_CHANNELS(2)) if2 ();

    conv_layer #(.Q_WIDTH(16), .FILTER_SIZE(2), .IMAGE_SIZE(64)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    conv_layer #(.Q_WIDTH(10), .FILTER_SIZE(2), .IMAGE_SIZE(64)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    conv_layer #(.Q_WIDTH(16), .FILTER_SIZE(3), .IMAGE_SIZE(8))  dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        bit v0; int s0;
        bit v1; int s1;
        bit v2; int s2;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned hist[$];     // accepted pixels, newest first, {c0,c1}
    int          n_acc  = 0;
    int          checks = 0;
    int          errors = 0;
    bit          sb_on  = 1'b0;
    int          cur_a0, cur_a1;
    bit          cur_en, cur_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_sum(int a0, int a1, int fs, int is, int qw);
        int s = 0;
        for (int r = 0; r < fs; r++) begin
            for (int c = 0; c < fs; c++) begin
                int off = r * is + c;
                if (off == 0) s += a0 + a1;
                else if (off - 1 < hist.size())
                    s += int'((hist[off-1] >> 8) & 255) + int'(hist[off-1] & 255);
            end
        end
        return s % (1 << qw);
    endfunction

    task automatic drive(input int a0, input int a1, input bit en, input bit r);
        exp_t e;
        cur_a0 = a0; cur_a1 = a1; cur_en = en; cur_r = r;
        if0.input_data = {a0[7:0], a1[7:0]};
        if1.input_data = {a0[7:0], a1[7:0]};
        if2.input_data = {a0[7:0], a1[7:0]};
        if0.clk_en = en; if1.clk_en = en; if2.clk_en = en;
        rst = r;
        e.v0 = (n_acc >= 65); e.s0 = model_sum(a0, a1, 2, 64, 16);
        e.v1 = (n_acc >= 65); e.s1 = model_sum(a0, a1, 2, 64, 10);
        e.v2 = (n_acc >= 18); e.s2 = model_sum(a0, a1, 3, 8, 16);
        if (sb_on) sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_r) begin
            hist.delete();
            n_acc = 0;
        end else if (cur_en) begin
            hist.push_front({16'd0, cur_a0[7:0], cur_a1[7:0]});
            if (hist.size() > 256) void'(hist.pop_back());
            if (n_acc < 1000) n_acc++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("d0_valid", 32'(if0.valid), 32'(mon_e.v0));
            chk("d0_ch0",   32'(if0.output_data[31:16]), mon_e.s0);
            chk("d0_ch1",   32'(if0.output_data[15:0]),  mon_e.s0);
            chk("d1_valid", 32'(if1.valid), 32'(mon_e.v1));
            chk("d1_ch0",   32'(if1.output_data[19:10]), mon_e.s1);
            chk("d1_ch1",   32'(if1.output_data[9:0]),   mon_e.s1);
            chk("d2_valid", 32'(if2.valid), 32'(mon_e.v2));
            chk("d2_ch0",   32'(if2.output_data[31:16]), mon_e.s2);
            chk("d2_ch1",   32'(if2.output_data[15:0]),  mon_e.s2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.clk_en = 1'b0; if1.clk_en = 1'b0; if2.clk_en = 1'b0;
        if0.input_data = '0; if1.input_data = '0; if2.input_data = '0;
        @(posedge clk); #1;
        drive(0, 0, 1'b0, 1'b1); tick();
        drive(0, 0, 1'b0, 1'b1); tick();
        sb_on = 1'b1;

        // Reset state: only the live pixel contributes
        drive(3, 4, 1'b0, 1'b0); #2;
        chk("rst_valid", 32'(if0.valid), 32'd0);
        chk("rst_sum",   32'(if0.output_data), 32'h0007_0007);
        tick();

        for (int i = 0; i < 70; i++) begin
            drive(1, 1, 1'b1, 1'b0);
            if (i == 17) begin #2; chk("ones_d2_v17", 32'(if2.valid), 32'd0); end
            if (i == 18) begin #2; chk("ones_d2_v18", 32'(if2.valid), 32'd1);
                                   chk("ones_d2_sum", 32'(if2.output_data[15:0]), 32'd18); end
            if (i == 64) begin #2; chk("ones_d0_v64", 32'(if0.valid), 32'd0); end
            if (i == 65) begin #2; chk("ones_d0_v65", 32'(if0.valid), 32'd1);
                                   chk("ones_d0_sum", 32'(if0.output_data), 32'h0008_0008); end
            tick();
        end

        drive(0, 0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 200; i++) begin
            drive(i & 255, (2 * i) & 255, 1'b1, 1'b0);
            if (i == 128) begin #2; chk("ramp_row_edge", 32'(if0.output_data[31:16]), 32'd890); end
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            drive(77 + j, 9 * j, 1'b0, 1'b0); tick();
        end
        for (int i = 200; i < 270; i++) begin
            drive(i & 255, (2 * i) & 255, 1'b1, 1'b0);
            if (i == 200) begin #2; chk("resume_sum", 32'(if0.output_data[15:0]), 32'd986); end
            tick();
        end

        for (int i = 0; i < 70; i++) begin
            drive(255, 255, 1'b1, 1'b0);
            if (i == 69) begin #2;
                chk("ff_q16", 32'(if0.output_data[15:0]), 32'd2040);
                chk("ff_q10", 32'(if1.output_data[9:0]),  32'd1016);
                chk("ff_3x3", 32'(if2.output_data[15:0]), 32'd4590);
            end
            tick();
        end

        drive(0, 0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 100; i++) begin
            drive(i & 255, (3 * i) & 255, 1'b1, 1'b0); tick();
        end
        drive(9, 9, 1'b1, 1'b1); tick();
        for (int j = 0; j < 66; j++) begin
            drive(5, 6, 1'b1, 1'b0);
            if (j == 0)  begin #2; chk("midrst_valid", 32'(if0.valid), 32'd0);
                                   chk("midrst_sum", 32'(if0.output_data[31:16]), 32'd11); end
            if (j == 64) begin #2; chk("midrst_v64", 32'(if0.valid), 32'd0); end
            if (j == 65) begin #2; chk("midrst_v65", 32'(if0.valid), 32'd1); end
            tick();
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
